evo_scheduler: RTL
==================

# evo_scheduler

Generation scheduler and grid-RAM write arbiter for the Game-of-Life core. Decides when the `Round` evolution engine runs a generation: free-running at a selectable speed, or single-stepped while paused. Shares the single grid-RAM write port between `Round`, user cell edits and a whole-grid clear. Detects generation completion by counting `Round` write strobes.

## Interface
Parameters:
- `P_PARAM_M`, 5, grid rows
- `P_PARAM_N`, 5, grid columns
- `WIDTH`, 12, coordinate width; positions are `2*WIDTH` bits, linear `row*P_PARAM_N+col`
- `TICK_DIV`, 100000, clk cycles per base tick

Ports:
- `clk` in 1: the block's single clock
- `rst` in 1: asynchronous, active-high reset
- `run_toggle` in 1: one-cycle pulse; flips run/pause
- `step` in 1: one-cycle pulse; one generation, honoured only while paused
- `speed` in 3: generation period = `8-speed` base ticks (1..8)
- `clear` in 1: one-cycle pulse; write 0 to every cell
- `edit_req` in 1: level; held until `edit_ack`
- `edit_pos` in `2*WIDTH`: cell to write
- `edit_val` in 1: value to write
- `edit_ack` out 1: one-cycle pulse on the cycle the edit write is issued
- `global_evo_en` out 1: level; toggles once per generation start (`Round` triggers on change)
- `evo_wden` in 1: `Round` write strobe
- `round_write_pos` in `2*WIDTH`: `Round` write address
- `round_live` in 1: `Round` next-state bit
- `ram_wr_en` out 1: grid RAM write enable
- `ram_wr_pos` out `2*WIDTH`: grid RAM write address
- `ram_wr_data` out 1: grid RAM write data
- `running` out 1: run flag
- `busy` out 1: high in EVOLVE or CLEAR
- `gen_done` out 1: one-cycle pulse at generation end
- `gen_count` out 16: completed generations; wraps at 65535→0

## Operation
- Constant `CELLS = P_PARAM_M*P_PARAM_N`.
- States:
  - IDLE: paused.
  - WAIT: running; waiting for the period to elapse.
  - EVOLVE: generation in flight.
  - EDIT: one-cycle edit write.
  - CLEAR: sweep all cells to 0.
- Arbitration in IDLE/WAIT, highest priority first:
  - clear pending → CLEAR
  - `edit_req` → EDIT
  - IDLE with step pending, or WAIT with period elapsed → EVOLVE
- Entering EVOLVE:
  - toggle `global_evo_en`
  - clear the write counter
  - clear any pending step
- In EVOLVE:
  - RAM port is a combinational pass-through: `ram_wr_en=evo_wden`, `ram_wr_pos=round_write_pos`, `ram_wr_data=round_live`.
  - Each `evo_wden` increments the write counter.
  - On the `CELLS`-th strobe: `gen_count`+1, `gen_done` pulses, then → WAIT if `running`, else → IDLE.
- EDIT:
  - issue `ram_wr_en=1`, `ram_wr_pos=edit_pos`, `ram_wr_data=edit_val`, and assert `edit_ack` in the same cycle
  - return to the origin state (IDLE or WAIT)
  - Period counter is frozen during EDIT.
- CLEAR:
  - one write per cycle, address 0..`CELLS-1`, data 0
  - then → IDLE or WAIT per `running`
  - `gen_count` resets to 0 on CLEAR exit
- Deferral and pending requests:
  - `clear` arriving during EVOLVE or EDIT is latched and serviced next.
  - `edit_req` during EVOLVE/CLEAR waits; no ack until serviced.
  - `step` while running, or while already pending, is dropped; `step` during EVOLVE/CLEAR is latched as pending only if `running=0`.
  - `run_toggle` flips `running` in any state; the current EVOLVE/CLEAR always completes.
- Period counter:
  - restarts at entry to WAIT
  - counts base ticks; elapsed when count reaches `8-speed`
  - `speed` is sampled live; a new value below the current count elapses immediately
- Simultaneous `run_toggle` and `step`: the toggle applies; the step is evaluated against the new `running` value.
- `evo_wden` outside EVOLVE is ignored: no RAM write, no count.

## Timing
- Reset values: every output is 0, state IDLE, all counters and pending flags cleared.
- Reset mid-EVOLVE abandons the generation; `global_evo_en` returns to 0.
- Generation start: `global_evo_en` toggles the cycle after the start decision.
- `gen_done` is registered: it asserts the cycle after the final `evo_wden`, and the next state is entered on that same edge.
- EVOLVE → WAIT → EVOLVE minimum gap: `(8-speed)*TICK_DIV` cycles plus 1.
- Edit latency from `edit_req` in IDLE: `edit_ack` in cycle +1.
- CLEAR lasts exactly `CELLS` cycles with `ram_wr_en` high.

## Structure
- Package `life_pkg` holds:
  - state enum `sched_state_t`
  - `CELLS` as a localparam function of M and N
  - the 16-bit generation count type
- Sub-module `tick_divider` (counter to `TICK_DIV-1`, one-cycle `tick` pulse, enabled only in WAIT).

## Test plan
Common settings: M=N=5, `TICK_DIV`=4, stub `Round` issuing 25 `evo_wden` pulses.
- Reset then `step` pulse → `global_evo_en` toggles 0→1 one cycle later; after 25 strobes `gen_done` pulses and `gen_count`=1; state IDLE.
- `run_toggle`, `speed`=7 → generation starts every 4 cycles after each `gen_done`; `speed`=0 → every 32 cycles.
- `edit_req` with `edit_pos`=12, `edit_val`=1 held during EVOLVE → no ack until the cycle after `gen_done`; then a single write at 12 with data 1.
- `clear` mid-EVOLVE → generation finishes its 25 writes, then addresses 0..24 are written with 0; `gen_count`=0 afterwards.
- `step` while running → ignored (no extra generation); `rst` asserted mid-CLEAR → all outputs 0 immediately.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and sizing helpers for the Game-of-Life generation scheduler.
package life_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_EVOLVE,
      ST_EDIT,
      ST_CLEAR
   } sched_state_t;

   typedef logic [15:0] gen_count_t;

   function automatic int unsigned cells_of(input int unsigned m, input int unsigned n);
      return m * n;
   endfunction

endpackage

// File: rtl/evo_scheduler_tick_divider.sv
// Base-tick generator: one-cycle tick every TICK_DIV enabled cycles.
module tick_divider #(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Holding (rather than clearing) when disabled lets the period survive an edit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/evo_scheduler.sv
// Generation scheduler and grid-RAM write arbiter between Round, cell edits and clear.
module evo_scheduler
   import life_pkg::*;
#(
   parameter int unsigned P_PARAM_M = 5,
   parameter int unsigned P_PARAM_N = 5,
   parameter int unsigned WIDTH     = 12,
   parameter int unsigned TICK_DIV  = 100000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run_toggle,
   input  logic                 step,
   input  logic [2:0]           speed,
   input  logic                 clear,
   input  logic                 edit_req,
   input  logic [2*WIDTH-1:0]   edit_pos,
   input  logic                 edit_val,
   output logic                 edit_ack,
   output logic                 global_evo_en,
   input  logic                 evo_wden,
   input  logic [2*WIDTH-1:0]   round_write_pos,
   input  logic                 round_live,
   output logic                 ram_wr_en,
   output logic [2*WIDTH-1:0]   ram_wr_pos,
   output logic                 ram_wr_data,
   output logic                 running,
   output logic                 busy,
   output logic                 gen_done,
   output gen_count_t           gen_count
);

   localparam int unsigned CELLS = cells_of(P_PARAM_M, P_PARAM_N);
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CW    = $clog2(CELLS + 1);
   localparam logic [CW-1:0] LAST_WR  = CW'(CELLS - 1);
   localparam logic [PW-1:0] LAST_POS = PW'(CELLS - 1);

   sched_state_t  state;
   logic          run_next, step_pend, clr_pend, clear_hit, start;
   logic          tick, restart, elapsed;
   logic [3:0]    pcount, period;
   logic [CW-1:0] wr_cnt;
   logic [PW-1:0] clr_addr;

   // Period timing only runs in WAIT; EDIT freezes it, every other state rearms it.
   assign restart = (state == ST_IDLE) || (state == ST_EVOLVE) || (state == ST_CLEAR);

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .en      (state == ST_WAIT),
      .tick    (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcount <= '0;
      end else if (restart) begin
         pcount <= '0;
      end else if (tick) begin
         pcount <= pcount + 4'd1;
      end
   end

   assign period    = 4'd8 - {1'b0, speed};
   assign elapsed   = (pcount >= period);
   assign run_next  = running ^ run_toggle;
   assign clear_hit = clr_pend | clear;
   assign start     = run_next ? ((state == ST_WAIT) && elapsed) : (step_pend | step);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         running       <= 1'b0;
         global_evo_en <= 1'b0;
         gen_done      <= 1'b0;
         gen_count     <= '0;
         wr_cnt        <= '0;
         clr_addr      <= '0;
         step_pend     <= 1'b0;
         clr_pend      <= 1'b0;
      end else begin
         gen_done <= 1'b0;
         running  <= run_next;
         if (run_next)
            step_pend <= 1'b0;
         else if (step)
            step_pend <= 1'b1;
         if (clear && ((state == ST_EVOLVE) || (state == ST_EDIT)))
            clr_pend <= 1'b1;

         case (state)
            ST_IDLE, ST_WAIT: begin
               if (clear_hit) begin
                  state    <= ST_CLEAR;
                  clr_pend <= 1'b0;
                  clr_addr <= '0;
               end else if (edit_req) begin
                  state <= ST_EDIT;
               end else if (start) begin
                  state         <= ST_EVOLVE;
                  global_evo_en <= ~global_evo_en;
                  wr_cnt        <= '0;
                  step_pend     <= 1'b0;
               end else begin
                  state <= run_next ? ST_WAIT : ST_IDLE;
               end
            end
            ST_EVOLVE: begin
               if (evo_wden) begin
                  if (wr_cnt == LAST_WR) begin
                     gen_count <= gen_count + 16'd1;
                     gen_done  <= 1'b1;
                     state     <= run_next ? ST_WAIT : ST_IDLE;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            ST_EDIT: begin
               state <= run_next ? ST_WAIT : ST_IDLE;
            end
            ST_CLEAR: begin
               if (clr_addr == LAST_POS) begin
                  clr_addr  <= '0;
                  gen_count <= '0;
                  state     <= run_next ? ST_WAIT : ST_IDLE;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ram_wr_en   = 1'b0;
      ram_wr_pos  = '0;
      ram_wr_data = 1'b0;
      edit_ack    = 1'b0;
      case (state)
         ST_EVOLVE: begin
            ram_wr_en   = evo_wden;
            ram_wr_pos  = round_write_pos;
            ram_wr_data = round_live;
         end
         ST_EDIT: begin
            ram_wr_en   = 1'b1;
            ram_wr_pos  = edit_pos;
            ram_wr_data = edit_val;
            edit_ack    = 1'b1;
         end
         ST_CLEAR: begin
            ram_wr_en  = 1'b1;
            ram_wr_pos = clr_addr;
         end
         default: ;
      endcase
   end

   assign busy = (state == ST_EVOLVE) || (state == ST_CLEAR);

endmodule
